// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for the id stage.
// Opcode and funct encodings, enable levels and FSM states.
package id_stage_pipe_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_JALR    = 3'b000;
   localparam logic [2:0] F3_MUL     = 3'b000;
   localparam logic [2:0] F3_MULU    = 3'b011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;
   localparam logic READ_ENABLE   = 1'b1;
   localparam logic READ_DISABLE  = 1'b0;

   localparam int ZERO_REG = 0;

   typedef enum logic {
      ID_RUN   = 1'b0,
      ID_FLUSH = 1'b1
   } id_state_e;

endpackage

// File: rtl/id_decode_comb.sv
// Combinational RV32I (+MUL/MULU) decoder.
// Unused register fields and illegal encodings decode to zero.
module id_decode_comb
   import id_stage_pipe_pkg::*;
#(
   parameter int RADDR_W  = 5,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0]        inst,
   output logic               rs1_used,
   output logic               rs2_used,
   output logic [RADDR_W-1:0] rs1_addr,
   output logic [RADDR_W-1:0] rs2_addr,
   output logic [RADDR_W-1:0] rd_addr,
   output logic               reg_w_ena,
   output logic               mem_w_ena,
   output logic               mem_r_ena,
   output logic               illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       use1, use2, wr, ld, st, legal;
   logic       m_ok, r_ok, i_ok;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   assign m_ok = ENABLE_M && funct7 == F7_MUL &&
                 (funct3 == F3_MUL || funct3 == F3_MULU);
   assign r_ok = funct7 == F7_ZERO || m_ok ||
                 (funct7 == F7_ALT &&
                  (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));

   always_comb begin
      i_ok = 1'b1;
      if (funct3 == F3_SLL)
         i_ok = funct7 == F7_ZERO;
      else if (funct3 == F3_SRL_SRA)
         i_ok = funct7 == F7_ZERO || funct7 == F7_ALT;
   end

   always_comb begin
      use1  = 1'b0;
      use2  = 1'b0;
      wr    = 1'b0;
      ld    = 1'b0;
      st    = 1'b0;
      legal = 1'b0;
      unique case (1'b1)
         opcode == OP_R: begin
            {use1, use2, wr} = 3'b111;
            legal = r_ok;
         end
         opcode == OP_I: begin
            {use1, wr} = 2'b11;
            legal = i_ok;
         end
         opcode == OP_LUI,
         opcode == OP_AUIPC,
         opcode == OP_JAL: begin
            wr    = 1'b1;
            legal = 1'b1;
         end
         opcode == OP_JALR: begin
            {use1, wr} = 2'b11;
            legal = funct3 == F3_JALR;
         end
         opcode == OP_LOAD: begin
            {use1, wr, ld} = 3'b111;
            legal = funct3 != 3'b011 && funct3[2:1] != 2'b11;
         end
         opcode == OP_STORE: begin
            {use1, use2, st} = 3'b111;
            legal = funct3[2] == 1'b0 && funct3[1:0] != 2'b11;
         end
         opcode == OP_BRANCH: begin
            {use1, use2} = 2'b11;
            legal = funct3[2:1] != 2'b01;
         end
         default: legal = 1'b0;
      endcase
   end

   assign illegal   = !legal;
   assign rs1_used  = legal & use1;
   assign rs2_used  = legal & use2;
   assign rs1_addr  = rs1_used ? inst[15 +: RADDR_W] : '0;
   assign rs2_addr  = rs2_used ? inst[20 +: RADDR_W] : '0;
   assign rd_addr   = (legal & wr) ? inst[7 +: RADDR_W] : '0;
   assign reg_w_ena = (legal & wr) ? WRITE_ENABLE : WRITE_DISABLE;
   assign mem_w_ena = (legal & st) ? WRITE_ENABLE : WRITE_DISABLE;
   assign mem_r_ena = (legal & ld) ? READ_ENABLE : READ_DISABLE;

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage between if_id and ex.
// Handles operand bypass, load-use bubbles, jump squash and backpressure.
module id_stage_pipe
   import id_stage_pipe_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RADDR_W      = 5,
   parameter bit ENABLE_M     = 1'b1,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        inst_i,
   input  logic [XLEN-1:0]    inst_addr_i,
   input  logic               inst_valid_i,
   output logic               id_ready_o,
   output logic [RADDR_W-1:0] reg1_r_addr_o,
   output logic [RADDR_W-1:0] reg2_r_addr_o,
   input  logic [XLEN-1:0]    reg1_r_data_i,
   input  logic [XLEN-1:0]    reg2_r_data_i,
   input  logic               wb_w_ena_i,
   input  logic [RADDR_W-1:0] wb_w_addr_i,
   input  logic [XLEN-1:0]    wb_w_data_i,
   input  logic               ex_jump_ena_i,
   input  logic               ex_ready_i,
   output logic               valid_o,
   output logic [31:0]        inst_o,
   output logic [XLEN-1:0]    inst_addr_o,
   output logic [XLEN-1:0]    reg1_r_data_o,
   output logic [XLEN-1:0]    reg2_r_data_o,
   output logic               reg_w_ena_o,
   output logic [RADDR_W-1:0] reg_w_addr_o,
   output logic               mem_w_ena_o,
   output logic               mem_r_ena_o,
   output logic               illegal_o
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [RADDR_W-1:0] X0 = RADDR_W'(ZERO_REG);

   logic               d_rs1_used, d_rs2_used;
   logic [RADDR_W-1:0] d_rs1, d_rs2, d_rd;
   logic               d_w_ena, d_mw, d_mr, d_ill;
   logic [XLEN-1:0]    op1, op2;
   logic               hazard, ready, slot_load, slot_clear;
   id_state_e          state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;

   id_decode_comb #(
      .RADDR_W  (RADDR_W),
      .ENABLE_M (ENABLE_M)
   ) u_dec (
      .inst      (inst_i),
      .rs1_used  (d_rs1_used),
      .rs2_used  (d_rs2_used),
      .rs1_addr  (d_rs1),
      .rs2_addr  (d_rs2),
      .rd_addr   (d_rd),
      .reg_w_ena (d_w_ena),
      .mem_w_ena (d_mw),
      .mem_r_ena (d_mr),
      .illegal   (d_ill)
   );

   assign reg1_r_addr_o = d_rs1;
   assign reg2_r_addr_o = d_rs2;
   assign id_ready_o    = ready;

   // x0 never bypasses, so a wb match implies a non-zero address
   assign op1 = (d_rs1 == X0) ? '0 :
                (wb_w_ena_i && wb_w_addr_i == d_rs1) ? wb_w_data_i :
                reg1_r_data_i;
   assign op2 = (d_rs2 == X0) ? '0 :
                (wb_w_ena_i && wb_w_addr_i == d_rs2) ? wb_w_data_i :
                reg2_r_data_i;

   assign hazard = valid_o && mem_r_ena_o && reg_w_addr_o != X0 &&
                   ((d_rs1_used && d_rs1 == reg_w_addr_o) ||
                    (d_rs2_used && d_rs2 == reg_w_addr_o));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ID_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (ex_jump_ena_i) begin
         cnt_nx   = CNT_W'(FLUSH_CYCLES - 1);
         state_nx = (FLUSH_CYCLES > 1) ? ID_FLUSH : ID_RUN;
      end else if (state == ID_FLUSH && inst_valid_i) begin
         cnt_nx = cnt - 1'b1;
         if (cnt == CNT_W'(1))
            state_nx = ID_RUN;
      end
   end

   always_comb begin
      ready      = 1'b0;
      slot_load  = 1'b0;
      slot_clear = 1'b0;
      if (!rst) begin
         if (ex_jump_ena_i || state == ID_FLUSH) begin
            ready      = 1'b1;
            slot_clear = 1'b1;
         end else begin
            ready = (!valid_o || ex_ready_i) && !hazard;
            if (valid_o && !ex_ready_i)
               slot_clear = 1'b0;
            else if (inst_valid_i && ready)
               slot_load = 1'b1;
            else
               slot_clear = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || slot_clear) begin
         valid_o       <= 1'b0;
         inst_o        <= '0;
         inst_addr_o   <= '0;
         reg1_r_data_o <= '0;
         reg2_r_data_o <= '0;
         reg_w_ena_o   <= 1'b0;
         reg_w_addr_o  <= '0;
         mem_w_ena_o   <= 1'b0;
         mem_r_ena_o   <= 1'b0;
         illegal_o     <= 1'b0;
      end else if (slot_load) begin
         valid_o       <= 1'b1;
         inst_o        <= inst_i;
         inst_addr_o   <= inst_addr_i;
         reg1_r_data_o <= op1;
         reg2_r_data_o <= op2;
         reg_w_ena_o   <= d_w_ena;
         reg_w_addr_o  <= d_rd;
         mem_w_ena_o   <= d_mw;
         mem_r_ena_o   <= d_mr;
         illegal_o     <= d_ill;
      end
   end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe.
// Directed scenarios plus random traffic against a rule-level model.
module tb_id_stage_pipe;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, inst_addr_i;
   logic        inst_valid_i;
   logic [31:0] reg1_r_data_i, reg2_r_data_i, wb_w_data_i;
   logic        wb_w_ena_i, ex_jump_ena_i, ex_ready_i;
   logic [4:0]  wb_w_addr_i;

   logic        id_ready_o, valid_o, reg_w_ena_o;
   logic        mem_w_ena_o, mem_r_ena_o, illegal_o;
   logic [4:0]  reg1_r_addr_o, reg2_r_addr_o, reg_w_addr_o;
   logic [31:0] inst_o, inst_addr_o, reg1_r_data_o, reg2_r_data_o;

   logic        m0_ready, m0_valid, m0_wen, m0_mw, m0_mr, m0_ill;
   logic [4:0]  m0_a1, m0_a2, m0_wa;
   logic [31:0] m0_inst, m0_addr, m0_op1, m0_op2;

   always #5 clk = ~clk;

   id_stage_pipe #(
      .XLEN(32), .RADDR_W(5), .ENABLE_M(1'b1), .FLUSH_CYCLES(FC)
   ) dut (
      .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .inst_valid_i(inst_valid_i), .id_ready_o(id_ready_o),
      .reg1_r_addr_o(reg1_r_addr_o), .reg2_r_addr_o(reg2_r_addr_o),
      .reg1_r_data_i(reg1_r_data_i), .reg2_r_data_i(reg2_r_data_i),
      .wb_w_ena_i(wb_w_ena_i), .wb_w_addr_i(wb_w_addr_i),
      .wb_w_data_i(wb_w_data_i), .ex_jump_ena_i(ex_jump_ena_i),
      .ex_ready_i(ex_ready_i), .valid_o(valid_o), .inst_o(inst_o),
      .inst_addr_o(inst_addr_o), .reg1_r_data_o(reg1_r_data_o),
      .reg2_r_data_o(reg2_r_data_o), .reg_w_ena_o(reg_w_ena_o),
      .reg_w_addr_o(reg_w_addr_o), .mem_w_ena_o(mem_w_ena_o),
      .mem_r_ena_o(mem_r_ena_o), .illegal_o(illegal_o)
   );

   id_stage_pipe #(
      .XLEN(32), .RADDR_W(5), .ENABLE_M(1'b0), .FLUSH_CYCLES(1)
   ) dut_m0 (
      .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .inst_valid_i(inst_valid_i), .id_ready_o(m0_ready),
      .reg1_r_addr_o(m0_a1), .reg2_r_addr_o(m0_a2),
      .reg1_r_data_i(reg1_r_data_i), .reg2_r_data_i(reg2_r_data_i),
      .wb_w_ena_i(wb_w_ena_i), .wb_w_addr_i(wb_w_addr_i),
      .wb_w_data_i(wb_w_data_i), .ex_jump_ena_i(ex_jump_ena_i),
      .ex_ready_i(ex_ready_i), .valid_o(m0_valid), .inst_o(m0_inst),
      .inst_addr_o(m0_addr), .reg1_r_data_o(m0_op1),
      .reg2_r_data_o(m0_op2), .reg_w_ena_o(m0_wen),
      .reg_w_addr_o(m0_wa), .mem_w_ena_o(m0_mw),
      .mem_r_ena_o(m0_mr), .illegal_o(m0_ill)
   );

   typedef struct {
      logic [31:0] inst;
      logic [31:0] addr;
      logic [31:0] op1;
      logic [31:0] op2;
      logic        wen;
      logic [4:0]  wa;
      logic        mw;
      logic        mr;
      logic        ill;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_chk = 0;
   int          n_pass = 0;
   logic        m_valid;
   logic [4:0]  m_ld_rd;
   int          m_flush;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Instruction classes straight from the ISA tables
   function automatic void ref_dec(input logic [31:0] i, input logic m,
      output logic u1, output logic u2, output logic wr,
      output logic ld, output logic st, output logic ok);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = i[14:12];
      f7 = i[31:25];
      {u1, u2, wr, ld, st, ok} = 6'b0;
      case (i[6:0])
         7'h33: begin
            {u1, u2, wr} = 3'b111;
            ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) ||
                 (m && f7 == 7'h01 && (f3 == 0 || f3 == 3));
         end
         7'h13: begin
            {u1, wr} = 2'b11;
            ok = (f3 == 1) ? f7 == 0 :
                 (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
         end
         7'h37, 7'h17, 7'h6f: begin wr = 1; ok = 1; end
         7'h67: begin {u1, wr} = 2'b11; ok = f3 == 0; end
         7'h03: begin
            {u1, wr, ld} = 3'b111;
            ok = f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
         end
         7'h23: begin {u1, u2, st} = 3'b111; ok = f3 <= 2; end
         7'h63: begin {u1, u2} = 2'b11; ok = f3 != 2 && f3 != 3; end
         default: ok = 0;
      endcase
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0] op;
      logic [6:0] f7;
      case ($urandom_range(0, 11))
         0, 1: op = 7'h33;
         2: op = 7'h13;
         3: op = 7'h37;
         4: op = 7'h17;
         5: op = 7'h6f;
         6: op = 7'h67;
         7, 8: op = 7'h03;
         9: op = 7'h23;
         10: op = 7'h63;
         default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0: f7 = 7'h00;
         1: f7 = 7'h20;
         2: f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              3'($urandom), 5'($urandom_range(0, 7)), op};
   endfunction

   task automatic step(input logic iv, input logic [31:0] ins,
                       input logic jmp, input logic exr, input logic r,
                       input int wbf);
      logic u1, u2, wr, ld, st, ok, haz, er;
      logic [4:0] a1, a2;
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      inst_valid_i  = iv;
      inst_i        = ins;
      inst_addr_i   = $urandom;
      ex_jump_ena_i = jmp;
      ex_ready_i    = exr;
      reg1_r_data_i = $urandom;
      reg2_r_data_i = $urandom;
      if (wbf < 0) begin
         wb_w_ena_i  = 1'($urandom_range(0, 1));
         wb_w_addr_i = 5'($urandom_range(0, 7));
      end else begin
         wb_w_ena_i  = 1'b1;
         wb_w_addr_i = 5'(wbf);
      end
      wb_w_data_i = $urandom;
      #1;
      chk("valid_o", valid_o, m_valid);
      ref_dec(ins, 1'b1, u1, u2, wr, ld, st, ok);
      a1  = (ok && u1) ? ins[19:15] : 5'd0;
      a2  = (ok && u2) ? ins[24:20] : 5'd0;
      haz = m_valid && m_ld_rd != 0 && (a1 == m_ld_rd || a2 == m_ld_rd);
      er  = !r && (jmp || m_flush > 0 || ((!m_valid || exr) && !haz));
      chk("id_ready_o", id_ready_o, er);
      chk("reg1_r_addr_o", reg1_r_addr_o, a1);
      chk("reg2_r_addr_o", reg2_r_addr_o, a2);
      if (r) begin
         sb.delete();
         m_valid = 0;
         m_flush = 0;
      end else if (jmp) begin
         if (m_valid) void'(sb.pop_front());
         m_valid = 0;
         m_flush = FC - 1;
      end else if (m_flush > 0) begin
         m_valid = 0;
         if (iv) m_flush--;
      end else if (m_valid && !exr) begin
         m_valid = 1;
      end else if (iv && er) begin
         e.inst = ins;
         e.addr = inst_addr_i;
         e.op1  = (a1 == 0) ? 0 : (wb_w_ena_i && wb_w_addr_i == a1) ?
                  wb_w_data_i : reg1_r_data_i;
         e.op2  = (a2 == 0) ? 0 : (wb_w_ena_i && wb_w_addr_i == a2) ?
                  wb_w_data_i : reg2_r_data_i;
         e.wen  = ok && wr;
         e.wa   = (ok && wr) ? ins[11:7] : 5'd0;
         e.mw   = ok && st;
         e.mr   = ok && ld;
         e.ill  = !ok;
         sb.push_back(e);
         m_valid = 1;
         m_ld_rd = (ok && ld) ? ins[11:7] : 5'd0;
      end else begin
         m_valid = 0;
      end
   endtask

   always @(negedge clk) begin
      if (!rst && valid_o && ex_ready_i && !ex_jump_ena_i) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_valid", valid_o, 1'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("inst_o", inst_o, mon_e.inst);
            chk("inst_addr_o", inst_addr_o, mon_e.addr);
            chk("reg1_r_data_o", reg1_r_data_o, mon_e.op1);
            chk("reg2_r_data_o", reg2_r_data_o, mon_e.op2);
            chk("reg_w_ena_o", reg_w_ena_o, mon_e.wen);
            chk("reg_w_addr_o", reg_w_addr_o, mon_e.wa);
            chk("mem_w_ena_o", mem_w_ena_o, mon_e.mw);
            chk("mem_r_ena_o", mem_r_ena_o, mon_e.mr);
            chk("illegal_o", illegal_o, mon_e.ill);
         end
      end
   end

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, valid_o, 0);
      chk({nm, "_inst"}, inst_o, 0);
      chk({nm, "_addr"}, inst_addr_o, 0);
      chk({nm, "_op1"}, reg1_r_data_o, 0);
      chk({nm, "_op2"}, reg2_r_data_o, 0);
      chk({nm, "_wen_wa"}, {reg_w_ena_o, reg_w_addr_o}, 0);
      chk({nm, "_mem_ill"}, {mem_w_ena_o, mem_r_ena_o, illegal_o}, 0);
   endtask

   localparam logic [31:0] ADD3  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
   localparam logic [31:0] LW5   = {12'd0, 5'd1, 3'd2, 5'd5, 7'h03};
   localparam logic [31:0] ADD6  = {7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33};
   localparam logic [31:0] MUL7  = {7'h01, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33};
   localparam logic [31:0] ADDI4 = {12'd9, 5'd3, 3'd0, 5'd4, 7'h13};
   localparam logic [31:0] ORI2  = {12'd5, 5'd4, 3'd6, 5'd2, 7'h13};

   logic [31:0] snap_inst, snap_op1, wbd;

   initial begin
      rst = 1'b1;
      {inst_valid_i, ex_jump_ena_i, ex_ready_i, wb_w_ena_i} = 4'b0;
      inst_i = 0; inst_addr_i = 0; wb_w_addr_i = 0; wb_w_data_i = 0;
      reg1_r_data_i = 0; reg2_r_data_i = 0;
      m_valid = 0; m_ld_rd = 0; m_flush = 0;

      step(0, 0, 0, 1, 1, -1);
      step(0, 0, 0, 1, 1, -1);
      step(0, 0, 0, 1, 0, -1);
      chk_zero("reset");

      step(1, ADD3, 0, 1, 0, -1);
      step(0, 0, 0, 1, 0, -1);
      chk("t1_valid", valid_o, 1);
      chk("t1_wa", reg_w_addr_o, 3);
      chk("t1_wen", reg_w_ena_o, 1);
      chk("t1_mem", {mem_w_ena_o, mem_r_ena_o}, 0);

      step(1, LW5, 0, 1, 0, -1);
      step(1, ADD6, 0, 1, 0, -1);
      chk("t2_stall", id_ready_o, 0);
      step(1, ADD6, 0, 1, 0, 5);
      wbd = wb_w_data_i;
      chk("t2_bubble", valid_o, 0);
      step(0, 0, 0, 1, 0, -1);
      chk("t2_bypass", reg1_r_data_o, wbd);

      step(1, ADDI4, 1, 1, 0, -1);
      step(1, ORI2, 0, 1, 0, -1);
      chk("t3_drop1", valid_o, 0);
      step(1, ADD3, 0, 1, 0, -1);
      chk("t3_drop2", valid_o, 0);
      step(0, 0, 0, 1, 0, -1);
      chk("t3_issue", inst_o, ADD3);

      step(1, ADDI4, 0, 1, 0, -1);
      step(1, ORI2, 0, 0, 0, -1);
      snap_inst = inst_o;
      snap_op1  = reg1_r_data_o;
      for (int k = 0; k < 2; k++) begin
         step(1, ORI2, 0, 0, 0, -1);
         chk("t4_hold_inst", inst_o, snap_inst);
         chk("t4_hold_op1", reg1_r_data_o, snap_op1);
         chk("t4_hold_ready", id_ready_o, 0);
      end
      step(1, ORI2, 0, 1, 0, -1);
      step(0, 0, 0, 1, 0, -1);
      chk("t4_next", inst_o, ORI2);

      step(0, 0, 0, 1, 1, -1);
      step(1, MUL7, 0, 1, 0, -1);
      step(0, 0, 0, 1, 0, -1);
      chk("t5_m1_wen", reg_w_ena_o, 1);
      chk("t5_m0_ill", m0_ill, 1);
      chk("t5_m0_wen", m0_wen, 0);
      chk("t5_m0_valid", m0_valid, 1);
      chk("t5_m0_wa", m0_wa, 0);

      step(1, ADDI4, 1, 1, 0, -1);
      step(1, ORI2, 0, 1, 0, -1);
      step(0, 0, 0, 1, 0, -1);
      chk("fc1_valid", m0_valid, 1);
      chk("fc1_inst", m0_inst, ORI2);

      step(1, ADDI4, 1, 1, 0, -1);
      step(1, ORI2, 0, 1, 1, -1);
      step(1, ADD3, 0, 1, 0, -1);
      chk_zero("t6_rst");
      step(0, 0, 0, 1, 0, -1);
      chk("t6_issue", inst_o, ADD3);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, rand_inst(),
              $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 199) == 0, -1);
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 1, 0, -1);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
